// File: rtl/spi_alu_master_if.sv
// Host handshake and SPI pin bundle for the serial ALU initiator.
interface spi_alu_master_if;
  logic        start;
  logic [2:0]  opcode;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        nss;
  logic        sclk;
  logic        mosi;
  logic        miso;

  // Initiator view: owns the SPI pins and the host status outputs
  modport master (
    input  start, opcode, opa, opb, miso,
    output busy, done, result, nss, sclk, mosi
  );

  // Opposite view: host request lines plus the slave's miso
  modport slave (
    output start, opcode, opa, opb, miso,
    input  busy, done, result, nss, sclk, mosi
  );
endinterface

// File: rtl/spi_alu_master.sv
// SPI mode-0 initiator for the serial ALU slave. A host request is sent as
// a 67-bit command frame, nss is released for a gap, then the 32-bit result
// is clocked back and presented with a one-cycle done pulse.
module spi_alu_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input logic              clock,
  input logic              reset,
  spi_alu_master_if.master bus
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DIV_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [DIV_W-1:0] HALF_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST    = DIV_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       TX_LAST_BIT = 7'd66;
  localparam logic [6:0]       RX_LAST_BIT = 7'd31;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    GAP,
    RX
  } state_t;

  state_t           state_q;
  logic             nss_q;
  logic             sclk_q;
  logic             mosi_q;
  logic             busy_q;
  logic             done_q;
  logic             tail_q;
  logic [31:0]      result_q;
  logic [31:0]      rxShift_q;
  logic [65:0]      txShift_q;
  logic [6:0]       bitCnt_q;
  logic [DIV_W-1:0] divCnt_q;

  logic             halfEnd_d;
  logic             gapEnd_d;
  logic [66:0]      frame_d;

  // Frame assembly and divider terminal-count decodes
  always_comb begin
    frame_d   = {bus.opcode, bus.opa, bus.opb};
    halfEnd_d = (divCnt_q == HALF_LAST);
    gapEnd_d  = (divCnt_q == GAP_LAST);
  end

  // Transaction sequencer; every SPI pin and host status bit is a register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      nss_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tail_q    <= 1'b0;
      result_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      bitCnt_q  <= '0;
      divCnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= TX;
            busy_q    <= 1'b1;
            nss_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= frame_d[66];
            txShift_q <= frame_d[65:0];
            rxShift_q <= '0;
            bitCnt_q  <= '0;
            divCnt_q  <= '0;
            tail_q    <= 1'b0;
          end
        end

        TX: begin
          if (!halfEnd_d) begin
            divCnt_q <= divCnt_q + 1'b1;
          end else begin
            divCnt_q <= '0;
            if (tail_q) begin
              tail_q  <= 1'b0;
              nss_q   <= 1'b1;
              state_q <= GAP;
            end else if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bitCnt_q == TX_LAST_BIT) begin
                mosi_q   <= 1'b0;
                tail_q   <= 1'b1;
                bitCnt_q <= '0;
              end else begin
                bitCnt_q  <= bitCnt_q + 1'b1;
                mosi_q    <= txShift_q[65];
                txShift_q <= {txShift_q[64:0], 1'b0};
              end
            end
          end
        end

        GAP: begin
          if (gapEnd_d) begin
            divCnt_q <= '0;
            nss_q    <= 1'b0;
            state_q  <= RX;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end

        RX: begin
          if (!halfEnd_d) begin
            divCnt_q <= divCnt_q + 1'b1;
          end else begin
            divCnt_q <= '0;
            if (tail_q) begin
              tail_q   <= 1'b0;
              nss_q    <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              result_q <= rxShift_q;
              state_q  <= IDLE;
            end else if (!sclk_q) begin
              sclk_q    <= 1'b1;
              rxShift_q <= {rxShift_q[30:0], bus.miso};
            end else begin
              sclk_q <= 1'b0;
              if (bitCnt_q == RX_LAST_BIT) begin
                tail_q   <= 1'b1;
                bitCnt_q <= '0;
              end else begin
                bitCnt_q <= bitCnt_q + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.nss    = nss_q;
  assign bus.sclk   = sclk_q;
  assign bus.mosi   = mosi_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_spi_alu_master.sv
// Bench for spi_alu_master: a default instance (CLK_DIV=4, GAP_CYCLES=8) and
// a minimum-timing instance (1/1) share one SPI slave model through a lane
// select. Expected frames and results go into scoreboard queues when a
// request is driven and are retired when the slave or host sees output.
module tb_spi_alu_master;

  localparam int PERIOD  = 10;
  localparam int TIMEOUT = 3000;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        sel     = 1'b0;
  logic        hStart  = 1'b0;
  logic [2:0]  hOpcode = '0;
  logic [31:0] hOpa    = '0;
  logic [31:0] hOpb    = '0;
  logic        sMiso   = 1'b0;

  logic        hBusy, hDone, hNss;
  logic [31:0] hResult;
  logic        sNss, sSclk, sMosi;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [66:0] frameQ[$];
  logic [31:0] resultQ[$];

  spi_alu_master_if bus0 ();
  spi_alu_master_if bus1 ();

  spi_alu_master #(.CLK_DIV(4), .GAP_CYCLES(8)) uDut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  spi_alu_master #(.CLK_DIV(1), .GAP_CYCLES(1)) uDut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #(PERIOD / 2) clock = ~clock;

  assign bus0.start  = sel ? 1'b0 : hStart;
  assign bus1.start  = sel ? hStart : 1'b0;
  assign bus0.opcode = hOpcode;
  assign bus1.opcode = hOpcode;
  assign bus0.opa    = hOpa;
  assign bus1.opa    = hOpa;
  assign bus0.opb    = hOpb;
  assign bus1.opb    = hOpb;
  assign bus0.miso   = sMiso;
  assign bus1.miso   = sMiso;

  assign hBusy   = sel ? bus1.busy   : bus0.busy;
  assign hDone   = sel ? bus1.done   : bus0.done;
  assign hNss    = sel ? bus1.nss    : bus0.nss;
  assign hResult = sel ? bus1.result : bus0.result;
  assign sNss    = sel ? bus1.nss    : bus0.nss;
  assign sSclk   = sel ? bus1.sclk   : bus0.sclk;
  assign sMosi   = sel ? bus1.mosi   : bus0.mosi;

  // Reference behaviour of the serial ALU slave
  function automatic logic [31:0] aluModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'b100:  return a << b[4:0];
      3'b101:  return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  function automatic int curDiv();
    return sel ? 1 : 4;
  endfunction

  function automatic int curGap();
    return sel ? 1 : 8;
  endfunction

  task automatic checkOutput(input string tag, input logic [66:0] observed,
                             input logic [66:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // SPI slave model: captures the command frame, answers with the ALU result
  logic        lastNss   = 1'b1;
  logic        lastSclk  = 1'b0;
  logic        rxPhase   = 1'b0;
  logic        periodBad = 1'b0;
  logic        mosiDirty = 1'b0;
  logic [66:0] capFrame  = '0;
  logic [31:0] respWord  = '0;
  int          capBits   = 0;
  int          rxBits    = 0;
  int          respIdx   = 0;
  longint      tFall     = 0;
  longint      tRise     = 0;
  longint      tSclk     = -1;

  always @(sNss or sSclk) begin : slaveModel
    if (sNss !== lastNss) begin
      lastNss = sNss;
      if (sNss === 1'b0) begin
        tFall     = longint'($time);
        tSclk     = -1;
        periodBad = 1'b0;
        if (rxPhase) begin
          checkOutput("gapCycles", 67'((tFall - tRise) / PERIOD), 67'(curGap()));
          rxBits    = 0;
          mosiDirty = 1'b0;
          respIdx   = 31;
          sMiso     = respWord[31];
        end else begin
          capFrame = '0;
          capBits  = 0;
        end
      end else if (sNss === 1'b1) begin
        tRise = longint'($time);
        if (reset !== 1'b1) begin
          rxPhase = 1'b0;
          sMiso   = 1'b0;
        end else if (!rxPhase) begin
          checkOutput("txBits", 67'(capBits), 67'(67));
          checkOutput("txNssLow", 67'((tRise - tFall) / PERIOD), 67'(135 * curDiv()));
          checkOutput("txSclkPeriod", 67'(periodBad), 67'(0));
          if (frameQ.size() == 0) checkOutput("frameQueue", 67'(0), 67'(1));
          else checkOutput("frame", capFrame, frameQ.pop_front());
          respWord = aluModel(capFrame[66:64], capFrame[63:32], capFrame[31:0]);
          rxPhase  = 1'b1;
        end else begin
          checkOutput("rxBits", 67'(rxBits), 67'(32));
          checkOutput("rxNssLow", 67'((tRise - tFall) / PERIOD), 67'(65 * curDiv()));
          checkOutput("rxSclkPeriod", 67'(periodBad), 67'(0));
          checkOutput("rxMosiZero", 67'(mosiDirty), 67'(0));
          rxPhase = 1'b0;
          sMiso   = 1'b0;
        end
      end
    end
    if (sSclk !== lastSclk) begin
      lastSclk = sSclk;
      if (sNss === 1'b0 && sSclk === 1'b1) begin
        if (tSclk >= 0 && (longint'($time) - tSclk) != longint'(2 * curDiv() * PERIOD))
          periodBad = 1'b1;
        tSclk = longint'($time);
        if (rxPhase) begin
          rxBits++;
          if (sMosi !== 1'b0) mosiDirty = 1'b1;
        end else begin
          capFrame = {capFrame[65:0], sMosi};
          capBits++;
        end
      end else if (sNss === 1'b0 && sSclk === 1'b0 && rxPhase && respIdx > 0) begin
        respIdx--;
        sMiso = respWord[respIdx];
      end
    end
  end

  // Host-side monitor: retires expected results on done
  logic prevDone = 1'b0;
  logic prevBusy = 1'b0;

  always @(negedge clock) begin : hostMonitor
    if (prevDone) checkOutput("doneWidth", 67'(hDone), 67'(0));
    if (hDone === 1'b1) begin
      checkOutput("busyWithDone", 67'(hBusy), 67'(0));
      checkOutput("busyBeforeDone", 67'(prevBusy), 67'(1));
      if (resultQ.size() == 0) checkOutput("unexpectedDone", 67'(1), 67'(0));
      else checkOutput("result", 67'(hResult), 67'(resultQ.pop_front()));
    end
    prevDone = (hDone === 1'b1);
    prevBusy = (hBusy === 1'b1);
  end

  // One transaction with optional one-cycle start pulses at cycle offsets
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int expLat,
                               input int glitchA, input int glitchB);
    int n;
    bit seen;
    @(negedge clock);
    hStart  = 1'b1;
    hOpcode = op;
    hOpa    = a;
    hOpb    = b;
    frameQ.push_back({op, a, b});
    resultQ.push_back(aluModel(op, a, b));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge clock);
      n++;
      if (hDone === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (n == 1) begin
          checkOutput("busyAfterStart", 67'(hBusy), 67'(1));
          hOpcode = 3'($urandom);
          hOpa    = $urandom;
          hOpb    = $urandom;
        end
        hStart = (n == glitchA || n == glitchB);
      end
    end
    hStart = 1'b0;
    if (!seen) checkOutput("doneTimeout", 67'(0), 67'(1));
    else checkOutput("latency", 67'(n), 67'(expLat));
    repeat (4) @(negedge clock);
    checkOutput("idleNss", 67'(hNss), 67'(1));
    checkOutput("idleBusy", 67'(hBusy), 67'(0));
  endtask

  // Two transactions with start held high throughout
  task automatic applyBackToBack(input logic [2:0] op1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [2:0] op2,
                                 input logic [31:0] a2, input logic [31:0] b2,
                                 input int expLat);
    int n;
    bit seen;
    @(negedge clock);
    hStart  = 1'b1;
    hOpcode = op1;
    hOpa    = a1;
    hOpb    = b1;
    frameQ.push_back({op1, a1, b1});
    resultQ.push_back(aluModel(op1, a1, b1));
    n    = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge clock);
      n++;
      if (hDone === 1'b1) seen = 1'b1;
      else if (n == 1) begin
        hOpcode = op2;
        hOpa    = a2;
        hOpb    = b2;
        frameQ.push_back({op2, a2, b2});
        resultQ.push_back(aluModel(op2, a2, b2));
      end
    end
    if (!seen) begin
      hStart = 1'b0;
      checkOutput("b2bDone1Timeout", 67'(0), 67'(1));
      return;
    end
    checkOutput("b2bLatency1", 67'(n), 67'(expLat));
    checkOutput("b2bNssAtDone", 67'(hNss), 67'(1));
    @(negedge clock);
    checkOutput("b2bNssFall", 67'(hNss), 67'(0));
    checkOutput("b2bBusyAgain", 67'(hBusy), 67'(1));
    hStart = 1'b0;
    n    = 1;
    seen = 1'b0;
    while (!seen && n < TIMEOUT) begin
      @(negedge clock);
      n++;
      if (hDone === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("b2bDone2Timeout", 67'(0), 67'(1));
    else checkOutput("b2bLatency2", 67'(n), 67'(expLat));
    repeat (4) @(negedge clock);
  endtask

  initial begin : mainSequence
    bit sawDone;
    repeat (4) @(negedge clock);
    checkOutput("rstNss", 67'(hNss), 67'(1));
    checkOutput("rstSclk", 67'(sSclk), 67'(0));
    checkOutput("rstMosi", 67'(sMosi), 67'(0));
    checkOutput("rstBusy", 67'(hBusy), 67'(0));
    checkOutput("rstDone", 67'(hDone), 67'(0));
    checkOutput("rstResult", 67'(hResult), 67'(0));
    checkOutput("rstNssLane1", 67'(bus1.nss), 67'(1));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    applyStimulus(3'b100, 32'h0000_0001, 32'h0000_0004, 809, 0, 0);
    applyStimulus(3'b000, 32'hDEAD_BEEF, 32'h0000_0000, 809, 0, 0);
    applyStimulus(3'b101, 32'hF0F0_0000, 32'h0000_0008, 809, 544, 600);
    applyBackToBack(3'b101, 32'h8000_0000, 32'd31, 3'b100, 32'hFFFF_FFFF, 32'd0, 809);

    // Abort in the middle of the command frame, around bit 20
    @(negedge clock);
    hStart  = 1'b1;
    hOpcode = 3'b011;
    hOpa    = 32'h1234_5678;
    hOpb    = 32'h9ABC_DEF0;
    @(negedge clock);
    hStart = 1'b0;
    repeat (2 * 4 * 20 + 2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abortNss", 67'(hNss), 67'(1));
    checkOutput("abortSclk", 67'(sSclk), 67'(0));
    checkOutput("abortBusy", 67'(hBusy), 67'(0));
    checkOutput("abortResult", 67'(hResult), 67'(0));
    repeat (3) @(negedge clock);
    reset   = 1'b1;
    sawDone = 1'b0;
    repeat (900) begin
      @(negedge clock);
      if (hDone === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abortNoDone", 67'(sawDone), 67'(0));
    checkOutput("abortResultHeld", 67'(hResult), 67'(0));
    applyStimulus(3'b100, 32'h0000_00A5, 32'h0000_0010, 809, 0, 0);

    // Minimum-timing instance
    @(negedge clock);
    sel = 1'b1;
    repeat (2) @(negedge clock);
    applyStimulus(3'b100, 32'h1234_5678, 32'h0000_0003, 202, 0, 0);
    applyStimulus(3'b110, 32'hCAFE_F00D, 32'h0F0F_0F0F, 202, 0, 0);
    applyBackToBack(3'b101, 32'h8000_0000, 32'd31, 3'b100, 32'hFFFF_FFFF, 32'd0, 202);

    checkOutput("frameQueueEmpty", 67'(frameQ.size()), 67'(0));
    checkOutput("resultQueueEmpty", 67'(resultQ.size()), 67'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin : watchdog
    repeat (60000) @(posedge clock);
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
